video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Source end of the 24-bit Video/VideoReady/VideoValid pixel stream consumed by the DVI controller.
//  Generates raster-ordered test frames (solid, colour bars, checkerboard, gradient).
//  Replaces the constant video/video_valid tie-offs in the board top level.
//  Stream is handshake-correct under arbitrary back-pressure; SOF/EOL flags mark frame and line boundaries.
// PARAMETERS
//  Width       800  active pixels per line (>=2)
//  Height      600  active lines per frame (>=2)
//  BarWidth    100  pixels per colour bar; bars 0..7, any X beyond bar 7 stays bar 7
//  CheckerLog2 5    checker square size = 2**CheckerLog2 pixels
// PORTS
//  Clock       in   1   system clock; all logic on rising edge
//  Reset       in   1   synchronous, active-low (0 = reset)
//  Enable      in   1   run request; sampled only at frame boundaries
//  Mode        in   2   0 solid, 1 bars, 2 checker, 3 gradient; sampled at frame boundaries
//  SolidColor  in   24  colour for Mode 0; sampled at frame boundaries
//  Video       out  24  pixel {R[23:16],G[15:8],B[7:0]}
//  VideoValid  out  1   Video holds a valid pixel
//  VideoReady  in   1   sink accepts pixel this cycle
//  SOF         out  1   current pixel is (0,0); meaningful only while VideoValid
//  EOL         out  1   current pixel is X=Width-1; meaningful only while VideoValid
//  FrameCount  out  8   completed frames, wraps 255->0
// BEHAVIOUR
//  Reset (Reset==0 at edge): VideoValid=0, Video=0, SOF=0, EOL=0, FrameCount=0, X=Y=0, state IDLE,
//   latched mode=0, latched colour=0. Reset wins over every other event, including mid-frame.
//  All outputs registered; VideoValid has no combinational path from VideoReady.
//  Transfer = VideoValid & VideoReady at a rising edge.
//  FSM:
//   IDLE: if Enable, latch Mode/SolidColor, load pixel (0,0), go STREAM; VideoValid=1 next cycle.
//   STREAM: VideoValid=1. No transfer -> Video/SOF/EOL held stable.
//    Transfer -> next pixel presented next cycle (zero bubbles under continuous Ready).
//    Raster: X++; at X=Width-1 wrap X=0, Y++; at (Width-1,Height-1) frame ends.
//   Frame end transfer: FrameCount++. If Enable=1: latch Mode/SolidColor, present (0,0) next cycle.
//    If Enable=0: VideoValid=0, go IDLE.
//   Mode/SolidColor/Enable changes mid-frame have no effect until the next frame boundary.
//  Pixel value at (X,Y), computed from the latched mode:
//   Mode 0: SolidColor.
//   Mode 1: k = bar index (counter incremented every BarWidth pixels, saturating at 7, cleared at X=0).
//    R={8{k[2]}}, G={8{k[1]}}, B={8{k[0]}}.
//   Mode 2: X[CheckerLog2]^Y[CheckerLog2] ? 24'hFFFFFF : 24'h000000.
//   Mode 3: R=G=B=X[7:0] (wraps every 256 pixels).
//  No multipliers or dividers; X/Y counters width = $clog2(Width)/$clog2(Height).
// TESTING
//  1 Reset 0 for 3 cycles, Enable=1, Mode=0, SolidColor=24'h123456, Ready=1 ->
//    VideoValid=0 during reset; VideoValid=1, SOF=1, Video=24'h123456 on the 2nd cycle after release.
//  2 Mode=1, Ready=1, Width=800 -> X=0..99 give 24'h000000, X=100 gives 24'h0000FF,
//    X=700..799 give 24'hFFFFFF; EOL=1 only at X=799.
//  3 Random Ready (50%) over a full frame -> every held pixel stable while Ready=0;
//    exactly Width*Height transfers; FrameCount 0->1; checker matches X[5]^Y[5].
//  4 Mode switched 1->3 mid-frame -> remaining pixels stay bars;
//    next frame SOF pixel = 24'h000000, X=255 gives 24'hFFFFFF, X=256 gives 24'h000000.
//  5 Enable dropped mid-frame -> frame completes; VideoValid=0 the cycle after the last transfer;
//    re-enable restarts at (0,0) with SOF=1.
//  6 Reset pulsed at X=300,Y=10 during a stall -> VideoValid=0 and FrameCount=0 next cycle;
//    stream restarts at (0,0).

Source files
------------

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster test-pattern source (solid, bars, checker, gradient) on a valid/ready pixel stream.
// Mode, colour and enable are captured only at frame boundaries; every output is registered.
module video_pattern_gen #(
    parameter int WIDTH        = 800,
    parameter int HEIGHT       = 600,
    parameter int BAR_WIDTH    = 100,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [1:0]  i_mode,
    input  logic [23:0] i_solid_color,
    output logic [23:0] o_video,
    output logic        o_video_valid,
    input  logic        i_video_ready,
    output logic        o_sof,
    output logic        o_eol,
    output logic [7:0]  o_frame_count
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int BW = $clog2(BAR_WIDTH + 1);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(BAR_WIDTH - 1);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [BW-1:0] r_bc;
    logic [2:0]    r_k;
    logic [1:0]    r_mode;
    logic [23:0]   r_color;
    logic          w_xfer, w_last_x, w_frame_end, w_load;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [BW-1:0] w_nbc;
    logic [2:0]    w_nk;
    logic [23:0]   w_pix_first, w_pix_adv;

    // r_bc counts pixels within the current bar so the bar index needs no divider
    always_comb begin
        w_xfer      = o_video_valid & i_video_ready;
        w_last_x    = r_x == X_LAST;
        w_frame_end = w_last_x && r_y == Y_LAST;
        w_load      = r_state == S_IDLE ? i_enable : w_xfer & w_frame_end & i_enable;
        w_nx        = w_last_x ? '0 : r_x + 1'b1;
        w_ny        = w_frame_end ? '0 : w_last_x ? r_y + 1'b1 : r_y;
        w_nbc       = (w_last_x || r_bc == BC_LAST) ? '0 : r_bc + 1'b1;
        w_nk        = w_last_x ? 3'd0 : (r_bc == BC_LAST && r_k != 3'd7) ? r_k + 3'd1 : r_k;
        w_pix_first = i_mode == 2'd0 ? i_solid_color : 24'h000000;
        w_pix_adv   = r_mode == 2'd0 ? r_color :
                      r_mode == 2'd1 ? {{8{w_nk[2]}}, {8{w_nk[1]}}, {8{w_nk[0]}}} :
                      r_mode == 2'd2 ? {24{w_nx[CHECKER_LOG2] ^ w_ny[CHECKER_LOG2]}} :
                                       {3{w_nx[7:0]}};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_bc          <= '0;
            r_k           <= '0;
            r_mode        <= '0;
            r_color       <= '0;
            o_video       <= '0;
            o_video_valid <= 1'b0;
            o_sof         <= 1'b0;
            o_eol         <= 1'b0;
            o_frame_count <= '0;
        end else begin
            if (w_load) begin
                r_mode  <= i_mode;
                r_color <= i_solid_color;
            end
            if (r_state == S_IDLE) begin
                if (i_enable) begin
                    r_state       <= S_STREAM;
                    o_video_valid <= 1'b1;
                    o_video       <= w_pix_first;
                    o_sof         <= 1'b1;
                end
            end else if (w_xfer) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_bc    <= w_nbc;
                r_k     <= w_nk;
                o_sof   <= w_load;
                o_eol   <= w_nx == X_LAST;
                o_video <= w_frame_end ? w_pix_first : w_pix_adv;
                if (w_frame_end) begin
                    o_frame_count <= o_frame_count + 8'd1;
                    if (!i_enable) begin
                        r_state       <= S_IDLE;
                        o_video_valid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed sequence with random back-pressure, checked every cycle
// against a raster/pixel reference model built from plain arithmetic.
module tb_video_pattern_gen;
    localparam int W  = 800;
    localparam int H  = 12;
    localparam int BW = 100;
    localparam int CL = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, rdy;
    logic [1:0]  mode;
    logic [23:0] color;
    logic [23:0] video;
    logic        valid, sof, eol;
    logic [7:0]  fc;

    always #5 clk = ~clk;

    video_pattern_gen #(.WIDTH(W), .HEIGHT(H), .BAR_WIDTH(BW), .CHECKER_LOG2(CL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode), .i_solid_color(color),
        .o_video(video), .o_video_valid(valid), .i_video_ready(rdy),
        .o_sof(sof), .o_eol(eol), .o_frame_count(fc)
    );

    int total = 0;
    int bad   = 0;
    int m_valid = 0, m_x = 0, m_y = 0, m_mode = 0, m_fc = 0, xcnt = 0;
    logic [23:0] m_color = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input int m, input logic [23:0] c, input int x, input int y);
        int k;
        k = x / BW;
        if (k > 7) k = 7;
        case (m)
            0:       return c;
            1:       return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
            2:       return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return {3{8'(x % 256)}};
        endcase
    endfunction

    task automatic tick(input logic r);
        logic p_rst, p_en, p_xfer, p_stall, p_sof;
        logic [1:0]  p_mode;
        logic [23:0] p_col, p_vid;
        int done;
        rdy = r;
        p_rst = rst_n; p_en = en; p_mode = mode; p_col = color;
        p_xfer = valid & r; p_stall = valid & ~r; p_vid = video; p_sof = sof;
        done = 0;
        @(posedge clk);
        if (!p_rst) begin
            m_valid = 0; m_x = 0; m_y = 0; m_mode = 0; m_color = '0; m_fc = 0; xcnt = 0;
        end else begin
            if (p_xfer) xcnt++;
            if (!m_valid) begin
                if (p_en) begin
                    m_valid = 1; m_x = 0; m_y = 0; m_mode = int'(p_mode); m_color = p_col;
                end
            end else if (r) begin
                if (m_x == W - 1) begin
                    m_x = 0;
                    if (m_y == H - 1) begin
                        m_y = 0; done = 1; m_fc = (m_fc + 1) % 256;
                        if (p_en) begin m_mode = int'(p_mode); m_color = p_col; end
                        else m_valid = 0;
                    end else m_y++;
                end else m_x++;
            end
        end
        #1;
        chk("valid", valid, m_valid);
        chk("frame_count", fc, m_fc);
        if (!p_rst) begin
            chk("reset_video", video, 0);
            chk("reset_sof", sof, 0);
            chk("reset_eol", eol, 0);
        end
        if (m_valid != 0) begin
            chk("video", video, ref_pix(m_mode, m_color, m_x, m_y));
            chk("sof", sof, m_x == 0 && m_y == 0);
            chk("eol", eol, m_x == W - 1);
            if (m_mode == 1 && (m_x <= 100 || m_x >= 700))
                chk("bar_spot", video, m_x < 100 ? 24'h000000 : m_x == 100 ? 24'h0000FF : 24'hFFFFFF);
            if (m_mode == 3 && (m_x == 255 || m_x == 256))
                chk("grad_spot", video, m_x == 255 ? 24'hFFFFFF : 24'h000000);
        end
        if (p_rst && rst_n && p_stall) begin
            chk("hold_video", video, p_vid);
            chk("hold_sof", sof, p_sof);
        end
        if (done != 0) begin
            chk("xfers_per_frame", xcnt, W * H);
            xcnt = 0;
        end
    endtask

    task automatic run_to(input int x, input int y, input bit rnd);
        int n;
        n = 0;
        while (!(m_valid != 0 && m_x == x && m_y == y) && n < 40000) begin
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("run_to_in_budget", n < 40000, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b1; mode = 2'd0; color = 24'h123456; rdy = 1'b1;
        repeat (3) tick(1'b1);
        rst_n = 1'b1;
        tick(1'b1);
        chk("t1_first_valid", valid, 1);
        chk("t1_first_sof", sof, 1);
        chk("t1_first_video", video, 24'h123456);
        run_to(400, 5, 1'b0);
        mode = 2'd1; color = 24'hABCDEF;
        run_to(0, 0, 1'b0);
        chk("t2_bars_sof_pixel", video, 24'h000000);
        run_to(500, 3, 1'b0);
        mode = 2'd3;
        run_to(0, 0, 1'b0);
        chk("t4_grad_sof_pixel", video, 24'h000000);
        chk("t4_grad_sof", sof, 1);
        run_to(10, 1, 1'b0);
        mode = 2'd2;
        run_to(0, 0, 1'b0);
        run_to(600, 8, 1'b1);
        en = 1'b0;
        n = 0;
        while (m_valid != 0 && n < 40000) begin
            tick(1'($urandom_range(0, 1)));
            n++;
        end
        chk("t5_drain_in_budget", n < 40000, 1);
        chk("t5_idle_valid", valid, 0);
        repeat (4) tick(1'b1);
        en = 1'b1;
        tick(1'b1);
        chk("t5_restart_valid", valid, 1);
        chk("t5_restart_sof", sof, 1);
        run_to(300, 10, 1'b1);
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b0;
        tick(1'b0);
        chk("t6_reset_valid", valid, 0);
        chk("t6_reset_fcount", fc, 0);
        mode = 2'd0; color = 24'h00FF00;
        rst_n = 1'b1;
        tick(1'b1);
        chk("t6_restart_sof", sof, 1);
        chk("t6_restart_video", video, 24'h00FF00);
        repeat (200) tick(1'($urandom_range(0, 1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
